// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad row scan, debounce and single-cycle key event.
// Optional macro KEYPAD_REPEAT_EN adds auto-repeat pulses while a key is held.
// Rev 1.0
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV        = 6000,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int REPEAT_CYCLES   = 1500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int C_MAX_SD = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int C_MAX    = (C_MAX_SD > REPEAT_CYCLES) ? C_MAX_SD : REPEAT_CYCLES;
  localparam int CNT_W    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

  localparam logic [CNT_W-1:0] c_scan_last = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_sync1;
  logic [3:0]       r_col_s;
  logic [1:0]       r_row;
  logic [3:0]       r_row_o;
  logic [1:0]       r_col;
  logic [3:0]       r_key;
  logic             r_valid;
  logic             r_held;

  logic [1:0]       w_low_col;
  logic [1:0]       w_row_next;
  logic [3:0]       w_row_o_next;
  logic [3:0]       w_map;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] c_rep_last = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] r_rep;
`endif

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;  4'b11_01: k = 4'h0;  4'b11_10: k = 4'hF;  default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Lowest-index active-low column wins when several keys share the driven row.
  always_comb begin
    w_low_col = 2'd0;
    if (!r_col_s[0])      w_low_col = 2'd0;
    else if (!r_col_s[1]) w_low_col = 2'd1;
    else if (!r_col_s[2]) w_low_col = 2'd2;
    else if (!r_col_s[3]) w_low_col = 2'd3;
  end

  assign w_row_next   = r_row + 2'd1;
  assign w_row_o_next = {r_row_o[2:0], r_row_o[3]};
  assign w_map        = key_map(r_row, r_col);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 4'b1111;
      r_col_s <= 4'b1111;
    end else begin
      r_sync1 <= col_i;
      r_col_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_SCAN;
      r_cnt   <= '0;
      r_row   <= 2'd0;
      r_row_o <= 4'b1110;
      r_col   <= 2'd0;
      r_key   <= 4'h0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      // Anything outside PRESSED clears the repeat count, covering entry and exit.
      r_rep   <= '0;
`endif
      case (r_state)
        S_SCAN: begin
          if (r_cnt == c_scan_last) begin
            r_cnt <= '0;
            if (r_col_s == 4'b1111) begin
              r_row   <= w_row_next;
              r_row_o <= w_row_o_next;
            end else begin
              r_col   <= w_low_col;
              r_state <= S_DEBOUNCE;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        S_DEBOUNCE: begin
          if (r_col_s[r_col]) begin
            r_cnt   <= '0;
            r_row   <= w_row_next;
            r_row_o <= w_row_o_next;
            r_state <= S_SCAN;
          end else if (r_cnt == c_deb_last) begin
            r_cnt   <= '0;
            r_key   <= w_map;
            r_valid <= 1'b1;
            r_held  <= 1'b1;
            r_state <= S_PRESSED;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        S_PRESSED: begin
          if (r_col_s == 4'b1111) begin
            r_cnt   <= '0;
            r_state <= S_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (!r_col_s[r_col]) begin
            if (r_rep == c_rep_last) begin
              r_rep   <= '0;
              r_valid <= 1'b1;
            end else begin
              r_rep <= r_rep + c_cnt_one;
            end
          end else begin
            r_rep <= r_rep;
          end
`endif
        end
        default: begin
          if (r_col_s != 4'b1111) begin
            r_cnt <= '0;
          end else if (r_cnt == c_deb_last) begin
            r_cnt   <= '0;
            r_held  <= 1'b0;
            r_row   <= w_row_next;
            r_row_o <= w_row_o_next;
            r_state <= S_SCAN;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
      endcase
    end
  end

  assign row_o       = r_row_o;
  assign key_o       = r_key;
  assign key_valid_o = r_valid;
  assign key_held_o  = r_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a 4x4 key-matrix model driving col_i from row_o.
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 20;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_REPEATS = 3;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] key_o;
  logic       key_valid_o;
  logic       key_held_o;
  logic [15:0] keys;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  logic [3:0] last_key = 4'h0;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rstn(rstn), .col_i(col_i), .row_o(row_o),
    .key_o(key_o), .key_valid_o(key_valid_o), .key_held_o(key_held_o)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low only while its row is driven low.
  always_comb begin
    col_i = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_o[r] && keys[r*4+c]) col_i[c] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid_o) begin
      pulse_cnt = pulse_cnt + 1;
      last_key  = key_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_pulse(input string name, input int max);
    int  base;
    bit  ok;
    base = pulse_cnt;
    ok   = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (pulse_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " pulse arrived"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_held(input string name, input logic val, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (key_held_o === val) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " held reached"}, {31'd0, ok}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_key;
    string       name;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base;

    tbl[0] = '{16'h0001, 4'h1, "key1"};
    tbl[1] = '{16'h0040, 4'h6, "key6"};
    tbl[2] = '{16'h0400, 4'h9, "key9"};
    tbl[3] = '{16'h8000, 4'hD, "keyD"};
    tbl[4] = '{16'h0800, 4'hC, "keyC"};
    tbl[5] = '{16'h0090, 4'h4, "row1_two_keys"};
    tbl[6] = '{16'h0200, 4'h8, "key8"};
    tbl[7] = '{16'h4000, 4'hF, "keyF"};

    // Reset values and row rotation.
    keys = 16'h0000;
    rstn = 1'b0;
    cycles(3);
    check("rst_row", {28'd0, row_o}, 32'hE);
    check("rst_key", {28'd0, key_o}, 32'h0);
    check("rst_valid", {31'd0, key_valid_o}, 32'd0);
    check("rst_held", {31'd0, key_held_o}, 32'd0);
    rstn = 1'b1;
    cycles(3);
    check("rot_hold0", {28'd0, row_o}, 32'hE);
    cycles(1);
    check("rot_row1", {28'd0, row_o}, 32'hD);
    cycles(4);
    check("rot_row2", {28'd0, row_o}, 32'hB);
    cycles(4);
    check("rot_row3", {28'd0, row_o}, 32'h7);
    cycles(4);
    check("rot_row0", {28'd0, row_o}, 32'hE);

    // Press A and hold: one pulse only.
    keys = 16'h0008;
    base = pulse_cnt;
    wait_pulse("pressA", 100);
    check("pressA_key", {28'd0, last_key}, 32'hA);
    check("pressA_held", {31'd0, key_held_o}, 32'd1);
    cycles(15);
    check("pressA_single", pulse_cnt - base, 32'd1);

    // Release bounce: short release then re-press must restart the release count.
    keys = 16'h0000;
    cycles(5);
    keys = 16'h0008;
    cycles(4);
    keys = 16'h0000;
    cycles(7);
    check("rel_bounce_held", {31'd0, key_held_o}, 32'd1);
    check("rel_bounce_nopulse", pulse_cnt - base, 32'd1);
    wait_held("releaseA", 1'b0, 40);
    check("rel_row_next", {28'd0, row_o}, 32'hD);

    // Bounce rejection on row 1: key 5 low for 5 cycles only.
    base = pulse_cnt;
    keys = 16'h0020;
    cycles(5);
    keys = 16'h0000;
    cycles(20);
    check("bounce_nopulse", pulse_cnt - base, 32'd0);
    check("bounce_held", {31'd0, key_held_o}, 32'd0);
    check("bounce_scan_row", {28'd0, row_o}, 32'hB);

    keys = 16'h0020;
    wait_pulse("press5", 100);
    check("press5_key", {28'd0, last_key}, 32'h5);
    keys = 16'h0000;
    wait_held("release5", 1'b0, 40);

    // Multi-key in row 3: col 0 wins; later keys elsewhere are ignored while held.
    keys = 16'h5000;
    base = pulse_cnt;
    wait_pulse("multi", 100);
    check("multi_key", {28'd0, last_key}, 32'hE);
    keys = 16'h5081;
    cycles(30);
    check("multi_ignore", pulse_cnt - base, 32'd1);
    check("multi_keyo", {28'd0, key_o}, 32'hE);
    keys = 16'h0000;
    wait_held("multi_rel", 1'b0, 40);

    // Table-driven single presses.
    for (int i = 0; i < 8; i++) begin
      keys = tbl[i].keys;
      base = pulse_cnt;
      wait_pulse(tbl[i].name, 100);
      check({tbl[i].name, "_key"}, {28'd0, last_key}, {28'd0, tbl[i].exp_key});
      check({tbl[i].name, "_held"}, {31'd0, key_held_o}, 32'd1);
      cycles(10);
      check({tbl[i].name, "_once"}, pulse_cnt - base, 32'd1);
      check({tbl[i].name, "_keyo"}, {28'd0, key_o}, {28'd0, tbl[i].exp_key});
      keys = 16'h0000;
      wait_held({tbl[i].name, "_rel"}, 1'b0, 40);
    end

    // Hold key 0 for 70 cycles after acceptance: repeats only with the macro.
    keys = 16'h2000;
    wait_pulse("hold0", 100);
    check("hold0_key", {28'd0, last_key}, 32'h0);
    base = pulse_cnt;
    cycles(70);
    keys = 16'h0000;
    check("hold0_repeats", pulse_cnt - base, EXP_REPEATS);
    check("hold0_last_key", {28'd0, last_key}, 32'h0);
    wait_held("hold0_rel", 1'b0, 40);

    // Reset while a key is held, then the still-held key is accepted afresh.
    keys = 16'h0400;
    wait_pulse("pre_rst", 100);
    rstn = 1'b0;
    #1;
    check("midrst_row", {28'd0, row_o}, 32'hE);
    check("midrst_key", {28'd0, key_o}, 32'h0);
    check("midrst_held", {31'd0, key_held_o}, 32'd0);
    check("midrst_valid", {31'd0, key_valid_o}, 32'd0);
    cycles(2);
    rstn = 1'b1;
    wait_pulse("post_rst", 100);
    check("post_rst_key", {28'd0, last_key}, 32'h9);
    keys = 16'h0000;
    wait_held("post_rst_rel", 1'b0, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
